// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : 32-bit single-cycle ALU with registered result and
//               zero / signed-less-than / unsigned-less-than status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [3:0]  ctrl,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  localparam logic [3:0] c_op_add   = 4'b0000;
  localparam logic [3:0] c_op_sub   = 4'b0001;
  localparam logic [3:0] c_op_and   = 4'b0010;
  localparam logic [3:0] c_op_or    = 4'b0011;
  localparam logic [3:0] c_op_xor   = 4'b0100;
  localparam logic [3:0] c_op_sll   = 4'b0101;
  localparam logic [3:0] c_op_srl   = 4'b0110;
  localparam logic [3:0] c_op_sra   = 4'b0111;
  localparam logic [3:0] c_op_slt   = 4'b1000;
  localparam logic [3:0] c_op_sltu  = 4'b1001;
  localparam logic [3:0] c_op_passb = 4'b1010;

  logic [4:0]  w_shamt;
  logic        w_lt_signed;
  logic        w_lt_unsigned;
  logic [31:0] w_result;
  logic [2:0]  w_flags;
  logic [31:0] r_result;
  logic [2:0]  r_flags;

  assign w_shamt       = src_b[4:0];
  assign w_lt_signed   = $signed(src_a) < $signed(src_b);
  assign w_lt_unsigned = src_a < src_b;

  always_comb begin
    w_result = 32'h0000_0000;
    case (ctrl)
      c_op_add:   w_result = src_a + src_b;
      c_op_sub:   w_result = src_a - src_b;
      c_op_and:   w_result = src_a & src_b;
      c_op_or:    w_result = src_a | src_b;
      c_op_xor:   w_result = src_a ^ src_b;
      c_op_sll:   w_result = src_a << w_shamt;
      c_op_srl:   w_result = src_a >> w_shamt;
      c_op_sra:   w_result = $signed(src_a) >>> w_shamt;
      c_op_slt:   w_result = {31'd0, w_lt_signed};
      c_op_sltu:  w_result = {31'd0, w_lt_unsigned};
      c_op_passb: w_result = src_b;
      default:    w_result = 32'h0000_0000;
    endcase
  end

  // Comparison flags are independent of the selected operation.
  assign w_flags = {(w_result == 32'h0000_0000), w_lt_signed, w_lt_unsigned};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= 32'h0000_0000;
      r_flags  <= 3'b000;
    end else begin
      r_result <= w_result;
      r_flags  <= w_flags;
    end
  end

  assign result = r_result;
  assign flags  = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module      : tb_alu
// Description : Scoreboard bench for alu: expected results are queued as
//               operands are driven and popped when the registered output
//               appears one edge later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  ctrl;
  logic [31:0] result;
  logic [2:0]  flags;

  int unsigned n_vec;
  int unsigned n_err;
  logic [34:0] exp_q[$];

  alu u_dut (
    .clk    (clk),
    .rst    (rst),
    .src_a  (src_a),
    .src_b  (src_b),
    .ctrl   (ctrl),
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op, input logic r);
    logic [31:0] res;
    logic        lts;
    logic        ltu;
    int          sh;
    logic [63:0] ext;
    sh  = int'(b[4:0]);
    lts = (a[31] != b[31]) ? a[31] : (a < b);
    ltu = (a < b);
    ext = {{32{a[31]}}, a};
    case (op)
      4'd0:    res = a + b;
      4'd1:    res = a + (~b) + 32'd1;
      4'd2:    res = a & b;
      4'd3:    res = a | b;
      4'd4:    res = a ^ b;
      4'd5:    res = a << sh;
      4'd6:    res = a >> sh;
      4'd7:    res = ext[31 + sh -: 32];
      4'd8:    res = {31'd0, lts};
      4'd9:    res = {31'd0, ltu};
      4'd10:   res = b;
      default: res = 32'd0;
    endcase
    if (r) return 35'd0;
    return {(res == 32'd0), lts, ltu, res};
  endfunction

  task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got result=%h flags=%b, expected result=%h flags=%b",
               tag, got[31:0], got[34:32], exp[31:0], exp[34:32]);
    end
  endtask

  // One operation per cycle: drive on the falling edge, check just after
  // the rising edge that captures it.
  task automatic apply(input string tag, input logic r, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    logic [34:0] exp;
    @(negedge clk);
    rst   = r;
    ctrl  = op;
    src_a = a;
    src_b = b;
    exp_q.push_back(model(a, b, op, r));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "/empty_queue"}, {flags, result}, 35'h7_FFFF_FFFF);
    end else begin
      exp = exp_q.pop_front();
      check(tag, {flags, result}, exp);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    ctrl  = 4'd0;
    src_a = 32'd0;
    src_b = 32'd0;

    apply("reset",      1'b1, 4'b0000, 32'h1234_5678, 32'h0000_0001);
    apply("add_wrap",   1'b0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
    apply("sub_neg",    1'b0, 4'b0001, 32'h0000_0005, 32'h0000_0007);
    apply("sra",        1'b0, 4'b0111, 32'h8000_0000, 32'hFFFF_FFE4);
    apply("srl",        1'b0, 4'b0110, 32'h8000_0000, 32'hFFFF_FFE4);
    apply("slt",        1'b0, 4'b1000, 32'hFFFF_FFFF, 32'h0000_0001);
    apply("sltu",       1'b0, 4'b1001, 32'hFFFF_FFFF, 32'h0000_0001);
    apply("unused_f",   1'b0, 4'b1111, 32'h1234_5678, 32'h1234_5678);
    apply("passb",      1'b0, 4'b1010, 32'h0000_0000, 32'hDEAD_BEEF);
    apply("sll_31",     1'b0, 4'b0101, 32'h0000_0003, 32'hFFFF_FFFF);
    apply("and",        1'b0, 4'b0010, 32'hF0F0_1234, 32'h0FF0_FFFF);
    apply("xor_zero",   1'b0, 4'b0100, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    apply("unused_b",   1'b0, 4'b1011, 32'h0000_0001, 32'h0000_0002);
    apply("rst_mid",    1'b1, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    apply("rst_release",1'b0, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
      if ($urandom_range(0, 9) == 0) a = {1'b1, 31'd0};
      apply("random", ($urandom_range(0, 19) == 0), op, a, b);
    end

    check("queue_drained", {3'd0, 32'(exp_q.size())}, 35'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
